// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver: majority vote per bit, glitch-start rejection, framing check.
// Define UART_RX_PARITY_EN to add a parity bit between the data and the stop bit.
module uart_rx_os16 #(
   parameter int unsigned SYS_CLK_FREQ = 50_000_000,
   parameter int unsigned BAUDRATE     = 115200,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic       sclk,
   input  logic       nrst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_done,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned TICK_MAX = SYS_CLK_FREQ / (BAUDRATE * 16) - 1;
   localparam int unsigned TickW    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
   localparam logic [TickW-1:0] TickMaxW = TickW'(TICK_MAX);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop,
      StBreak
   } state_e;

   state_e           state_q, state_d;
   logic             rx_meta_q, rx_meta_d;
   logic             rx_s_q, rx_s_d;
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]       smp_cnt_q, smp_cnt_d;
   logic             s7_q, s7_d, s8_q, s8_d, s9_q, s9_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             rx_done_q, rx_done_d;
   logic             frame_err_q, frame_err_d;
   logic             busy_q, busy_d;

   logic counting;
   logic tick;
   logic decide;
   logic bit_val;

`ifdef UART_RX_PARITY_EN
   localparam logic ParOdd = (PARITY_ODD != 0);
   logic par_bit_q, par_bit_d;
   logic parity_err_q, parity_err_d;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
`endif

   assign bit_val = (s7_q & s8_q) | (s7_q & s9_q) | (s8_q & s9_q);

   always_comb begin
      rx_meta_d   = rx;
      rx_s_d      = rx_meta_q;
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      smp_cnt_d   = smp_cnt_q;
      s7_d        = s7_q;
      s8_d        = s8_q;
      s9_d        = s9_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      rx_byte_d   = rx_byte_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
      busy_d      = busy_q;
`ifdef UART_RX_PARITY_EN
      par_bit_d    = par_bit_q;
      parity_err_d = 1'b0;
`endif

      counting = (state_q != StIdle) && (state_q != StBreak);
      tick     = counting && (tick_cnt_q == TickMaxW);
      decide   = tick && (smp_cnt_q == 4'd10);

      if (!counting || tick) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + TickW'(1);
      end

      // Sample points straddle mid-bit; the vote is taken one tick later.
      if (tick) begin
         smp_cnt_d = smp_cnt_q + 4'd1;
         if (smp_cnt_q == 4'd7) s7_d = rx_s_q;
         if (smp_cnt_q == 4'd8) s8_d = rx_s_q;
         if (smp_cnt_q == 4'd9) s9_d = rx_s_q;
      end

      case (state_q)
         StIdle: begin
            if (!rx_s_q) begin
               state_d   = StStart;
               smp_cnt_d = 4'd0;
               busy_d    = 1'b1;
            end
         end
         StStart: begin
            if (decide) begin
               if (bit_val) begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
               end else begin
                  state_d   = StData;
                  bit_idx_d = 3'd0;
               end
            end
         end
         StData: begin
            if (decide) begin
               shreg_d[bit_idx_q] = bit_val;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (decide) begin
               par_bit_d = bit_val;
               state_d   = StStop;
            end
         end
`endif
         StStop: begin
            if (decide) begin
               if (bit_val) begin
                  rx_byte_d = shreg_q;
                  rx_done_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_err_d = (par_bit_q != ((^shreg_q) ^ ParOdd));
`endif
                  state_d   = StIdle;
                  busy_d    = 1'b0;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
               end
            end
         end
         StBreak: begin
            // A line stuck low must release before another start edge is armed.
            if (rx_s_q) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= StIdle;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         tick_cnt_q  <= '0;
         smp_cnt_q   <= 4'd0;
         s7_q        <= 1'b1;
         s8_q        <= 1'b1;
         s9_q        <= 1'b1;
         bit_idx_q   <= 3'd0;
         shreg_q     <= 8'h00;
         rx_byte_q   <= 8'hFF;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         tick_cnt_q  <= tick_cnt_d;
         smp_cnt_q   <= smp_cnt_d;
         s7_q        <= s7_d;
         s8_q        <= s8_d;
         s9_q        <= s9_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         rx_byte_q   <= rx_byte_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_bit_q    <= par_bit_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_byte   = rx_byte_q;
   assign rx_done   = rx_done_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

`ifndef SYNTHESIS
   done_ferr_exclusive: assert property (@(posedge sclk) disable iff (!nrst)
      !(rx_done_q && frame_err_q));
`endif

endmodule
